// File: rtl/warp_fetch_decode.sv
// Front end of the 16-lane SIMT core: owns the PC, fetches instruction words over a
// variable-latency request/response port, decodes them and issues one at a time.
module warp_fetch_decode #(
  parameter int         ADDR_W  = 8,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [3:0]        issue_opcode,
  output logic [3:0]        issue_rd,
  output logic [3:0]        issue_rs2,
  output logic [3:0]        issue_rs1,
  output logic [ADDR_W-1:0] issue_pc,
  output logic              illegal,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ISSUE,
    S_HALTED
  } state_t;

  typedef enum logic [1:0] {
    DEC_OK,
    DEC_ILLEGAL,
    DEC_HALT
  } dec_t;

  // HALT is checked first so a HALT_OP inside 0..5 still terminates the program.
  function automatic dec_t classify(input logic [3:0] op, input logic [3:0] rd);
    dec_t cls;
    cls = DEC_OK;
    if (op == HALT_OP) begin
      cls = DEC_HALT;
    end else if ((op > 4'd5) || (rd == 4'hF)) begin
      cls = DEC_ILLEGAL;
    end
    return cls;
  endfunction

  state_t state, state_n;

  logic [ADDR_W-1:0] pc_p0;
  logic [3:0]        op_p1, rd_p1, rs2_p1, rs1_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic              illegal_p1;

  logic pc_clr, pc_inc, fields_ld, illegal_n;
  dec_t resp_cls;
  logic unused_resp_hi;

  assign unused_resp_hi = ^imem_resp_data[31:16];
  assign resp_cls       = classify(imem_resp_data[15:12], imem_resp_data[11:8]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_clr    = 1'b0;
    pc_inc    = 1'b0;
    fields_ld = 1'b0;
    illegal_n = 1'b0;
    case (state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_clr  = 1'b1;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_req_ready) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          case (resp_cls)
            DEC_HALT: begin
              state_n = S_HALTED;
            end
            DEC_ILLEGAL: begin
              illegal_n = 1'b1;
              pc_inc    = 1'b1;
              state_n   = S_REQ;
            end
            default: begin
              fields_ld = 1'b1;
              state_n   = S_ISSUE;
            end
          endcase
        end
      end
      S_ISSUE: begin
        if (issue_ready) begin
          // The last word of the address space ends the program instead of wrapping.
          if (pc_p0 == {ADDR_W{1'b1}}) begin
            state_n = S_HALTED;
          end else begin
            pc_inc  = 1'b1;
            state_n = S_REQ;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Stage p0: program counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p0 <= '0;
    end else if (pc_clr) begin
      pc_p0 <= '0;
    end else if (pc_inc) begin
      pc_p0 <= pc_p0 + 1'b1;
    end
  end

  // Stage p1: registered decode fields, held for the whole ISSUE state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_p1      <= '0;
      rd_p1      <= '0;
      rs2_p1     <= '0;
      rs1_p1     <= '0;
      pc_p1      <= '0;
      illegal_p1 <= 1'b0;
    end else begin
      illegal_p1 <= illegal_n;
      if (fields_ld) begin
        op_p1  <= imem_resp_data[15:12];
        rd_p1  <= imem_resp_data[11:8];
        rs2_p1 <= imem_resp_data[7:4];
        rs1_p1 <= imem_resp_data[3:0];
        pc_p1  <= pc_p0;
      end
    end
  end

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc_p0;
  assign issue_valid    = (state == S_ISSUE);
  assign issue_opcode   = op_p1;
  assign issue_rd       = rd_p1;
  assign issue_rs2      = rs2_p1;
  assign issue_rs1      = rs1_p1;
  assign issue_pc       = pc_p1;
  assign illegal        = illegal_p1;
  assign busy           = (state != S_IDLE) && (state != S_HALTED);
  assign halted         = (state == S_HALTED);

endmodule

// File: tb/tb_warp_fetch_decode.sv
// Scoreboard bench for warp_fetch_decode: a default-width instance and an ADDR_W=2
// instance share one memory responder and one issue monitor, selected by sel.
module tb_warp_fetch_decode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start_a, start_b, req_ready, resp_valid, issue_ready, sel;
  logic [31:0] resp_data;

  logic       a_req_valid, a_iss_valid, a_ill, a_busy, a_halted;
  logic [7:0] a_req_addr, a_pc;
  logic [3:0] a_op, a_rd, a_rs2, a_rs1;

  logic       b_req_valid, b_iss_valid, b_ill, b_busy, b_halted;
  logic [1:0] b_req_addr, b_pc;
  logic [3:0] b_op, b_rd, b_rs2, b_rs1;

  logic       m_req_valid, m_iss_valid, m_ill, m_busy, m_halted;
  logic [7:0] m_req_addr, m_pc;
  logic [3:0] m_op, m_rd, m_rs2, m_rs1;

  warp_fetch_decode #(.ADDR_W(8), .HALT_OP(4'hF)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .imem_req_valid(a_req_valid), .imem_req_addr(a_req_addr), .imem_req_ready(req_ready),
    .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
    .issue_valid(a_iss_valid), .issue_ready(issue_ready),
    .issue_opcode(a_op), .issue_rd(a_rd), .issue_rs2(a_rs2), .issue_rs1(a_rs1),
    .issue_pc(a_pc), .illegal(a_ill), .busy(a_busy), .halted(a_halted)
  );

  warp_fetch_decode #(.ADDR_W(2), .HALT_OP(4'hF)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .imem_req_valid(b_req_valid), .imem_req_addr(b_req_addr), .imem_req_ready(req_ready),
    .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
    .issue_valid(b_iss_valid), .issue_ready(issue_ready),
    .issue_opcode(b_op), .issue_rd(b_rd), .issue_rs2(b_rs2), .issue_rs1(b_rs1),
    .issue_pc(b_pc), .illegal(b_ill), .busy(b_busy), .halted(b_halted)
  );

  always_comb begin
    if (sel) begin
      m_req_valid = b_req_valid; m_req_addr = {6'b0, b_req_addr};
      m_iss_valid = b_iss_valid; m_pc = {6'b0, b_pc};
      m_op = b_op; m_rd = b_rd; m_rs2 = b_rs2; m_rs1 = b_rs1;
      m_ill = b_ill; m_busy = b_busy; m_halted = b_halted;
    end else begin
      m_req_valid = a_req_valid; m_req_addr = a_req_addr;
      m_iss_valid = a_iss_valid; m_pc = a_pc;
      m_op = a_op; m_rd = a_rd; m_rs2 = a_rs2; m_rs1 = a_rs1;
      m_ill = a_ill; m_busy = a_busy; m_halted = a_halted;
    end
  end

  typedef struct packed {
    logic [3:0] op, rd, rs2, rs1;
    logic [7:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, failures = 0;
  int          hs_cnt = 0, ill_cnt = 0, fetch_cnt = 0, fetch0_cnt = 0;
  int          mem_lat = 1, mem_stall = 0;
  logic [7:0]  last_fetch = 8'd0;
  logic [31:0] mem [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push(input logic [3:0] op, input logic [3:0] rd,
                               input logic [3:0] rs2, input logic [3:0] rs1,
                               input logic [7:0] pc);
    exp_t e;
    e = '{op: op, rd: rd, rs2: rs2, rs1: rs1, pc: pc};
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in cycle 1, i.e. just after the edge that samples start.
  task automatic pulse_start(input bit use_b);
    tick();
    if (use_b) start_b = 1'b1;
    else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_halted(input int budget);
    int n;
    n = 0;
    while (!m_halted && n < budget) begin
      tick();
      n++;
    end
    chk("halt_reached", {31'b0, m_halted}, 32'd1);
  endtask

  task automatic load_prog1();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_F000;
    mem[0] = 32'h0000_010F;
    mem[1] = 32'h0000_02FF;
    mem[2] = 32'h0000_0312;
    mem[3] = 32'h0000_F000;
  endtask

  task automatic push_prog1();
    push(4'h0, 4'h1, 4'h0, 4'hF, 8'd0);
    push(4'h0, 4'h2, 4'hF, 4'hF, 8'd1);
    push(4'h0, 4'h3, 4'h1, 4'h2, 8'd2);
  endtask

  // Memory responder: optional request backpressure, then a response mem_lat cycles after accept.
  initial begin
    bit         acc, fire, stalled, prev_stall, pending;
    logic [7:0] a, prev_addr, paddr;
    int         lat_cnt, stall_cnt;
    req_ready = 1'b1; resp_valid = 1'b0; resp_data = '0;
    prev_stall = 1'b0; pending = 1'b0; prev_addr = '0; paddr = '0;
    lat_cnt = 0; stall_cnt = 0;
    forever begin
      @(negedge clk);
      acc     = m_req_valid && req_ready;
      stalled = m_req_valid && !req_ready;
      a       = m_req_addr;
      fire    = resp_valid;
      if (prev_stall && m_req_valid) chk("req_addr_hold", {24'b0, a}, {24'b0, prev_addr});
      prev_stall = stalled;
      prev_addr  = a;
      @(posedge clk);
      #1;
      if (fire) resp_valid = 1'b0;
      if (!m_busy) stall_cnt = mem_stall;
      else if (stalled && stall_cnt > 0) stall_cnt--;
      if (acc) begin
        pending    = 1'b1;
        paddr      = a;
        lat_cnt    = mem_lat - 1;
        stall_cnt  = mem_stall;
        fetch_cnt++;
        last_fetch = a;
        if (a == 8'd0) fetch0_cnt++;
      end
      if (pending) begin
        if (lat_cnt == 0) begin
          resp_valid = 1'b1;
          resp_data  = mem[paddr];
          pending    = 1'b0;
        end else begin
          lat_cnt--;
        end
      end
      req_ready = (stall_cnt == 0);
    end
  end

  // Issue monitor: every handshake pops one expected instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_ill) ill_cnt++;
      if (m_iss_valid && issue_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_issue: actual pc=%0d required no issue", m_pc);
        end else begin
          e = exp_q.pop_front();
          chk("issue_fields", {8'b0, m_op, m_rd, m_rs2, m_rs1, m_pc}, {8'b0, e});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int         hs0, ill0, f0, fz0;
    logic [23:0] held;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; issue_ready = 1'b1; sel = 1'b0;
    load_prog1();
    repeat (3) tick();
    chk("rst_a_ctrl", {27'b0, a_req_valid, a_iss_valid, a_ill, a_busy, a_halted}, 32'd0);
    chk("rst_a_data", {a_req_addr, a_op, a_rd, a_rs2, a_rs1, a_pc}, 32'd0);
    chk("rst_b_ctrl", {27'b0, b_req_valid, b_iss_valid, b_ill, b_busy, b_halted}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic program, zero backpressure, 1-cycle memory: latency profile
    hs0 = hs_cnt; ill0 = ill_cnt;
    push_prog1();
    pulse_start(1'b0);
    chk("t1_req_c1", {23'b0, a_req_valid, a_req_addr}, {23'b0, 1'b1, 8'd0});
    chk("t1_busy_c1", {30'b0, a_busy, a_halted}, 32'b10);
    tick();
    chk("t1_noissue_c2", {31'b0, a_iss_valid}, 32'd0);
    tick();
    chk("t1_issue_c3", {31'b0, a_iss_valid}, 32'd1);
    tick();
    chk("t1_req_c4", {23'b0, a_req_valid, a_req_addr}, {23'b0, 1'b1, 8'd1});
    wait_halted(100);
    chk("t1_handshakes", hs_cnt - hs0, 32'd3);
    chk("t1_queue_empty", exp_q.size(), 32'd0);
    chk("t1_last_fetch", {24'b0, last_fetch}, 32'd3);
    chk("t1_not_busy", {31'b0, a_busy}, 32'd0);
    chk("t1_no_illegal", ill_cnt - ill0, 32'd0);

    // Issue backpressure for 5 cycles on the first instruction
    hs0 = hs_cnt;
    issue_ready = 1'b0;
    push_prog1();
    pulse_start(1'b0);
    chk("t2_halt_clears", {31'b0, a_halted}, 32'd0);
    for (int n = 0; n < 50 && !a_iss_valid; n++) tick();
    chk("t2_issue_seen", {31'b0, a_iss_valid}, 32'd1);
    held = {a_op, a_rd, a_rs2, a_rs1, a_pc};
    f0 = fetch_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold", {7'b0, a_iss_valid, a_op, a_rd, a_rs2, a_rs1, a_pc}, {7'b0, 1'b1, held});
      chk("t2_no_req", {31'b0, a_req_valid}, 32'd0);
      tick();
    end
    chk("t2_no_fetch_in_stall", fetch_cnt - f0, 32'd0);
    issue_ready = 1'b1;
    wait_halted(100);
    chk("t2_handshakes", hs_cnt - hs0, 32'd3);
    chk("t2_queue_empty", exp_q.size(), 32'd0);

    // Request backpressure of 3 cycles and 4-cycle response latency
    hs0 = hs_cnt;
    mem_stall = 3; mem_lat = 4;
    push_prog1();
    pulse_start(1'b0);
    chk("t3_backpressure", {31'b0, req_ready}, 32'd0);
    wait_halted(300);
    chk("t3_handshakes", hs_cnt - hs0, 32'd3);
    chk("t3_queue_empty", exp_q.size(), 32'd0);
    mem_stall = 0; mem_lat = 1;

    // Illegal opcode and illegal write to R15
    hs0 = hs_cnt; ill0 = ill_cnt;
    mem[0] = 32'h0000_7123; mem[1] = 32'h0000_0F12;
    mem[2] = 32'h0000_1412; mem[3] = 32'h0000_F000;
    push(4'h1, 4'h4, 4'h1, 4'h2, 8'd2);
    pulse_start(1'b0);
    wait_halted(100);
    chk("t4_illegal_pulses", ill_cnt - ill0, 32'd2);
    chk("t4_handshakes", hs_cnt - hs0, 32'd1);
    chk("t4_queue_empty", exp_q.size(), 32'd0);

    // ADDR_W=2 instance: no HALT, stops at the top of the address space
    sel = 1'b1;
    tick();
    hs0 = hs_cnt; f0 = fetch_cnt; fz0 = fetch0_cnt;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0000_5821;
    for (int i = 0; i < 4; i++) push(4'h5, 4'h8, 4'h2, 4'h1, 8'(i));
    pulse_start(1'b1);
    wait_halted(200);
    repeat (5) tick();
    chk("t5_handshakes", hs_cnt - hs0, 32'd4);
    chk("t5_fetches", fetch_cnt - f0, 32'd4);
    chk("t5_no_refetch0", fetch0_cnt - fz0, 32'd1);
    chk("t5_still_halted", {30'b0, b_halted, b_busy}, 32'b10);
    chk("t5_queue_empty", exp_q.size(), 32'd0);
    sel = 1'b0;
    tick();

    // Reset while a response is outstanding
    load_prog1();
    mem_lat = 4;
    hs0 = hs_cnt;
    pulse_start(1'b0);
    tick();
    chk("t6_in_wait", {30'b0, a_busy, a_req_valid}, 32'b10);
    reset = 1'b1;
    #1;
    chk("t6_rst_ctrl", {27'b0, a_req_valid, a_iss_valid, a_ill, a_busy, a_halted}, 32'd0);
    chk("t6_rst_addr", {24'b0, a_req_addr}, 32'd0);
    tick();
    reset = 1'b0;
    repeat (8) tick();
    chk("t6_late_resp_ignored", {30'b0, a_busy, a_iss_valid}, 32'd0);
    chk("t6_no_issue", hs_cnt - hs0, 32'd0);
    mem_lat = 1;
    push_prog1();
    pulse_start(1'b0);
    chk("t6_restart_pc0", {23'b0, a_req_valid, a_req_addr}, {23'b0, 1'b1, 8'd0});
    wait_halted(100);
    chk("t6_handshakes", hs_cnt - hs0, 32'd3);
    chk("t6_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
